// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one imem request at a time at the current PC,
// buffers returned words with their PC in a 2-entry FIFO and squashes work on redirect.
module fetch_stage #(
    parameter int IMEM_AW = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        i_pc_q,
    output logic               o_pc_en,
    output logic               o_pc_ld,
    output logic [31:0]        o_pc_next,
    input  logic               i_redirect_valid,
    input  logic [31:0]        i_redirect_pc,
    output logic               o_imem_req_valid,
    input  logic               i_imem_req_ready,
    output logic [IMEM_AW-1:0] o_imem_addr,
    input  logic               i_imem_rsp_valid,
    input  logic [31:0]        i_imem_rsp_data,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [31:0]        o_out_instr,
    output logic [31:0]        o_out_pc
);

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        DISCARD
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [1:0]  r_count;
    logic        r_head;
    logic        r_tail;
    logic [31:0] r_reqPc;
    logic [63:0] r_fifo [2];

    logic        w_issue;
    logic        w_push;
    logic        w_pop;

    assign o_imem_req_valid = (r_state == REQ) && (r_count < 2'd2) && !i_redirect_valid;
    assign o_imem_addr      = i_pc_q[IMEM_AW-1:0];
    assign w_issue          = o_imem_req_valid && i_imem_req_ready;
    assign w_push           = (r_state == WAIT) && i_imem_rsp_valid && !i_redirect_valid;
    assign w_pop            = o_out_valid && i_out_ready;

    assign o_out_valid = (r_count != 2'd0);
    assign o_out_instr = r_fifo[r_head][31:0];
    assign o_out_pc    = r_fifo[r_head][63:32];

    // A redirect loads the counter; otherwise the counter steps only on an accepted request.
    always_comb begin
        o_pc_en   = w_issue || i_redirect_valid;
        o_pc_ld   = i_redirect_valid;
        o_pc_next = i_redirect_valid ? i_redirect_pc : 32'd0;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            REQ: begin
                if (w_issue) w_nextState = WAIT;
            end
            WAIT: begin
                if (i_redirect_valid) w_nextState = i_imem_rsp_valid ? REQ : DISCARD;
                else if (i_imem_rsp_valid) w_nextState = REQ;
            end
            DISCARD: begin
                if (i_imem_rsp_valid) w_nextState = REQ;
            end
            default: w_nextState = REQ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= REQ;
            r_reqPc <= 32'd0;
        end else begin
            r_state <= w_nextState;
            if (w_issue) r_reqPc <= i_pc_q;
        end
    end

    // A redirect flushes the FIFO and voids any pop in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 2'd0;
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
        end else if (i_redirect_valid) begin
            r_count <= 2'd0;
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
        end else begin
            if (w_push) r_tail <= ~r_tail;
            if (w_pop) r_head <= ~r_head;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_tail] <= {r_reqPc, i_imem_rsp_data};
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: models the PC counter and a fixed-latency
// instruction memory, and scoreboards every instruction delivered to decode.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic [31:0] pcQ;
    logic        pcEn;
    logic        pcLd;
    logic [31:0] pcNext;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        reqValid;
    logic        reqReady;
    logic [31:0] imemAddr;
    logic        rspValid;
    logic [31:0] rspData;
    logic        outValid;
    logic        outReady;
    logic [31:0] outInstr;
    logic [31:0] outPc;

    int          checks;
    int          errors;
    int          popCount;
    int          memCnt;
    int          memLatency;
    logic [31:0] memAddr;
    logic [63:0] expQ [$];
    logic [31:0] issuedLog [$];

    fetch_stage #(.IMEM_AW(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_pc_q           (pcQ),
        .o_pc_en          (pcEn),
        .o_pc_ld          (pcLd),
        .o_pc_next        (pcNext),
        .i_redirect_valid (redirectValid),
        .i_redirect_pc    (redirectPc),
        .o_imem_req_valid (reqValid),
        .i_imem_req_ready (reqReady),
        .o_imem_addr      (imemAddr),
        .i_imem_rsp_valid (rspValid),
        .i_imem_rsp_data  (rspData),
        .o_out_valid      (outValid),
        .i_out_ready      (outReady),
        .o_out_instr      (outInstr),
        .o_out_pc         (outPc)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [31:0] memData(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h13572468;
    endfunction

    // Scoreboard and environment: sample mid-cycle, then advance counter and memory after the edge.
    task automatic finishCycle();
        logic        sIssue;
        logic        sEn;
        logic        sLd;
        logic [31:0] sNext;
        logic [31:0] sAddr;
        logic [63:0] expItem;
        sIssue = 1'b0;
        sEn    = 1'b0;
        sLd    = 1'b0;
        sNext  = 32'd0;
        sAddr  = pcQ;
        if (rst) begin
            expQ.delete();
        end else begin
            sIssue = reqValid && reqReady;
            if (redirectValid) begin
                checks++;
                if (pcEn !== 1'b1 || pcLd !== 1'b1 || pcNext !== redirectPc) begin
                    errors++;
                    $display("[TB] FAIL sb_redirect_ctrl: got en=%b ld=%b next=%h expected en=1 ld=1 next=%h",
                             pcEn, pcLd, pcNext, redirectPc);
                end
                checks++;
                if (reqValid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL sb_redirect_noreq: got req_valid=%b expected 0", reqValid);
                end
                expQ.delete();
            end else begin
                checks++;
                if (pcLd !== 1'b0 || pcNext !== 32'd0 || pcEn !== sIssue) begin
                    errors++;
                    $display("[TB] FAIL sb_pc_ctrl: got en=%b ld=%b next=%h expected en=%b ld=0 next=0",
                             pcEn, pcLd, pcNext, sIssue);
                end
                if (outValid && outReady) begin
                    checks++;
                    popCount++;
                    if (expQ.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL sb_unexpected_output: got pc=%h instr=%h expected no output",
                                 outPc, outInstr);
                    end else begin
                        expItem = expQ.pop_front();
                        if ({outPc, outInstr} !== expItem) begin
                            errors++;
                            $display("[TB] FAIL sb_output: got pc=%h instr=%h expected pc=%h instr=%h",
                                     outPc, outInstr, expItem[63:32], expItem[31:0]);
                        end
                    end
                end
                if (sIssue) begin
                    checks++;
                    if (imemAddr !== pcQ) begin
                        errors++;
                        $display("[TB] FAIL sb_req_addr: got %h expected %h", imemAddr, pcQ);
                    end
                    expQ.push_back({pcQ, memData(pcQ)});
                    issuedLog.push_back(pcQ);
                end
            end
            sEn   = pcEn;
            sLd   = pcLd;
            sNext = pcNext;
        end
        @(posedge clk);
        #1;
        if (rst) pcQ = 32'd0;
        else if (sEn) pcQ = sLd ? sNext : pcQ + 32'd1;
        rspValid = 1'b0;
        rspData  = 32'd0;
        if (memCnt > 0) begin
            memCnt--;
            if (memCnt == 0) begin
                rspValid = 1'b1;
                rspData  = memData(memAddr);
            end
        end
        if (sIssue) begin
            memAddr = sAddr;
            memCnt  = memLatency - 1;
            if (memCnt == 0) begin
                rspValid = 1'b1;
                rspData  = memData(memAddr);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        redirectValid = 1'b0;
        reqReady = 1'b0;
        outReady = 1'b1;
        #2;
        checks++;
        if (outValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", outValid);
        end
        checks++;
        if ({pcEn, pcLd, pcNext} !== 34'd0) begin
            errors++;
            $display("[TB] FAIL reset_pc_ctrl: got en=%b ld=%b next=%h expected all 0", pcEn, pcLd, pcNext);
        end
        finishCycle();
        rst = 1'b0;
        #2;
        checks++;
        if (reqValid !== 1'b1 || imemAddr !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_release_req: got valid=%b addr=%h expected valid=1 addr=0", reqValid, imemAddr);
        end
        finishCycle();
    endtask

    task automatic test_sequential();
        logic [31:0] startPc;
        startPc = pcQ;
        issuedLog.delete();
        popCount = 0;
        memLatency = 1;
        reqReady = 1'b1;
        outReady = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #2;
            finishCycle();
        end
        reqReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #2;
            finishCycle();
        end
        checks++;
        if (issuedLog.size() != 6) begin
            errors++;
            $display("[TB] FAIL seq_issue_count: got %0d expected 6", issuedLog.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (issuedLog[i] !== startPc + 32'(i)) begin
                    errors++;
                    $display("[TB] FAIL seq_issue_addr: got %h expected %h", issuedLog[i], startPc + 32'(i));
                end
            end
        end
        checks++;
        if (popCount != 6 || expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL seq_delivered: got %0d pops, %0d left expected 6 pops, 0 left", popCount, expQ.size());
        end
        checks++;
        if (pcQ !== startPc + 32'd6) begin
            errors++;
            $display("[TB] FAIL seq_pc_final: got %h expected %h", pcQ, startPc + 32'd6);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] startPc;
        startPc = pcQ;
        issuedLog.delete();
        popCount = 0;
        reqReady = 1'b1;
        outReady = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #2;
            if (i == 7) begin
                checks++;
                if (reqValid !== 1'b0 || outValid !== 1'b1 || pcEn !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL bp_full: got req=%b out_valid=%b en=%b expected req=0 out_valid=1 en=0",
                             reqValid, outValid, pcEn);
                end
            end
            finishCycle();
        end
        checks++;
        if (issuedLog.size() != 2 || pcQ !== startPc + 32'd2) begin
            errors++;
            $display("[TB] FAIL bp_issue_count: got %0d issues pc=%h expected 2 issues pc=%h",
                     issuedLog.size(), pcQ, startPc + 32'd2);
        end
        outReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #2;
            finishCycle();
        end
        reqReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #2;
            finishCycle();
        end
        checks++;
        if (issuedLog.size() < 3 || issuedLog[2] !== startPc + 32'd2) begin
            errors++;
            $display("[TB] FAIL bp_resume: got %0d issues expected resume at %h", issuedLog.size(), startPc + 32'd2);
        end
        checks++;
        if (popCount != 5 || expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL bp_drain: got %0d pops, %0d left expected 5 pops, 0 left", popCount, expQ.size());
        end
    endtask

    task automatic test_req_stall();
        logic [31:0] stallPc;
        stallPc = pcQ;
        issuedLog.delete();
        outReady = 1'b1;
        reqReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #2;
            checks++;
            if (reqValid !== 1'b1 || imemAddr !== stallPc || pcEn !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_hold: got req=%b addr=%h en=%b expected req=1 addr=%h en=0",
                         reqValid, imemAddr, pcEn, stallPc);
            end
            finishCycle();
        end
        reqReady = 1'b1;
        #2;
        checks++;
        if (pcEn !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_accept_en: got %b expected 1", pcEn);
        end
        finishCycle();
        reqReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #2;
            finishCycle();
        end
        checks++;
        if (pcQ !== stallPc + 32'd1 || issuedLog.size() != 1 || expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL stall_single_advance: got pc=%h issues=%0d left=%0d expected pc=%h issues=1 left=0",
                     pcQ, issuedLog.size(), expQ.size(), stallPc + 32'd1);
        end
    endtask

    task automatic test_redirect_wait();
        issuedLog.delete();
        popCount = 0;
        memLatency = 3;
        reqReady = 1'b1;
        outReady = 1'b1;
        #2;
        finishCycle();
        redirectValid = 1'b1;
        redirectPc = 32'h0000_0100;
        #2;
        checks++;
        if (pcLd !== 1'b1 || pcNext !== 32'h100 || pcEn !== 1'b1) begin
            errors++;
            $display("[TB] FAIL redir_ctrl: got en=%b ld=%b next=%h expected en=1 ld=1 next=00000100", pcEn, pcLd, pcNext);
        end
        finishCycle();
        redirectValid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #2;
            checks++;
            if (reqValid !== 1'b0 || pcLd !== 1'b0) begin
                errors++;
                $display("[TB] FAIL redir_discard: got req=%b ld=%b expected req=0 ld=0", reqValid, pcLd);
            end
            finishCycle();
        end
        #2;
        checks++;
        if (reqValid !== 1'b1 || imemAddr !== 32'h100) begin
            errors++;
            $display("[TB] FAIL redir_target_req: got req=%b addr=%h expected req=1 addr=00000100", reqValid, imemAddr);
        end
        finishCycle();
        reqReady = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #2;
            finishCycle();
        end
        checks++;
        if (popCount != 1 || expQ.size() != 0 || issuedLog.size() != 2) begin
            errors++;
            $display("[TB] FAIL redir_stale_dropped: got pops=%0d left=%0d issues=%0d expected 1, 0, 2",
                     popCount, expQ.size(), issuedLog.size());
        end
    endtask

    task automatic test_redirect_rsp();
        issuedLog.delete();
        popCount = 0;
        memLatency = 1;
        reqReady = 1'b1;
        outReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            finishCycle();
        end
        redirectValid = 1'b1;
        redirectPc = 32'h0000_0200;
        #2;
        checks++;
        if (outValid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rsp_redir_pre_fifo: got out_valid=%b expected 1", outValid);
        end
        finishCycle();
        redirectValid = 1'b0;
        #2;
        checks++;
        if (outValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rsp_redir_flush: got out_valid=%b expected 0", outValid);
        end
        checks++;
        if (reqValid !== 1'b1 || imemAddr !== 32'h200) begin
            errors++;
            $display("[TB] FAIL rsp_redir_next_req: got req=%b addr=%h expected req=1 addr=00000200", reqValid, imemAddr);
        end
        finishCycle();
        reqReady = 1'b0;
        outReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            finishCycle();
        end
        checks++;
        if (popCount != 1 || expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL rsp_redir_drain: got pops=%0d left=%0d expected 1, 0", popCount, expQ.size());
        end
    endtask

    task automatic test_reset_mid();
        memLatency = 3;
        reqReady = 1'b1;
        outReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #2;
            finishCycle();
        end
        #2;
        checks++;
        if (outValid !== 1'b1 || reqValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_pre: got out_valid=%b req=%b expected out_valid=1 req=0", outValid, reqValid);
        end
        rst = 1'b1;
        reqReady = 1'b0;
        #1;
        checks++;
        if (outValid !== 1'b0 || {pcEn, pcLd, pcNext} !== 34'd0) begin
            errors++;
            $display("[TB] FAIL rstmid_values: got out_valid=%b en=%b ld=%b next=%h expected all 0",
                     outValid, pcEn, pcLd, pcNext);
        end
        finishCycle();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #2;
            checks++;
            if (outValid !== 1'b0 || imemAddr !== 32'd0) begin
                errors++;
                $display("[TB] FAIL rstmid_late_rsp: got out_valid=%b addr=%h expected out_valid=0 addr=0",
                         outValid, imemAddr);
            end
            finishCycle();
        end
        outReady = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #2;
            finishCycle();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        popCount = 0;
        memCnt = 0;
        memLatency = 1;
        memAddr = 32'd0;
        rst = 1'b1;
        pcQ = 32'd0;
        redirectValid = 1'b0;
        redirectPc = 32'd0;
        reqReady = 1'b0;
        rspValid = 1'b0;
        rspData = 32'd0;
        outReady = 1'b0;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_backpressure();
        test_req_stall();
        test_redirect_wait();
        test_redirect_rsp();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of Hunter_RV32. It sits directly downstream of the 32-bit PC counter (enable/load counter, +1 per word) and drives that counter's `en`/`ld`/`data_in` controls. It issues one instruction-memory request at a time at the current PC and buffers returned words with their PC in a 2-entry FIFO. It delivers them to decode over a valid/ready handshake and squashes in-flight work on a branch redirect.

## Interface
- `IMEM_AW`, default 32: instruction-memory address width; `imem_addr` = `pc_q[IMEM_AW-1:0]`, word address.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pc_q`  in  32  current PC from the counter; word address.
- `pc_en`  out  1  counter enable.
- `pc_ld`  out  1  counter load select.
- `pc_next`  out  32  counter load value.
- `redirect_valid`  in  1  taken branch/jump from execute.
- `redirect_pc`  in  32  redirect target, word address.
- `imem_req_valid`  out  1  request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_addr`  out  IMEM_AW  request word address.
- `imem_rsp_valid`  in  1  response valid, always accepted; latency ≥1 cycle.
- `imem_rsp_data`  in  32  instruction word.
- `out_valid`  out  1  instruction available to decode.
- `out_ready`  in  1  decode accepts.
- `out_instr`  out  32  instruction at FIFO head.
- `out_pc`  out  32  PC of `out_instr`.

## Operation
- FSM states:
  - REQ: no request outstanding.
  - WAIT: one request outstanding, response wanted.
  - DISCARD: one request outstanding, response to be dropped.
- `imem_req_valid` = (state==REQ) && (count<2) && !redirect_valid.
- `imem_addr` = `pc_q`.
- Issue when `imem_req_valid && imem_req_ready`:
  - `req_pc <= pc_q`.
  - `pc_en`=1, `pc_ld`=0, so the counter advances by 1.
  - REQ→WAIT.
- WAIT with `imem_rsp_valid` and no redirect: push {`req_pc`, `imem_rsp_data`}; WAIT→REQ.
- DISCARD with `imem_rsp_valid`: drop the data; DISCARD→REQ.
- Redirect has priority over everything in the same cycle:
  - `pc_en`=1, `pc_ld`=1, `pc_next`=`redirect_pc`.
  - FIFO is flushed (count→0); any pop in that cycle is void.
  - WAIT→DISCARD, or WAIT→REQ if `imem_rsp_valid` is also asserted that cycle (response dropped).
  - DISCARD→REQ if `imem_rsp_valid`, otherwise stays DISCARD.
  - REQ stays REQ; no request issues in a redirect cycle.
- `pc_next` = 0 and `pc_ld` = 0 when not redirecting. `pc_en` = 0 when neither issuing nor redirecting.
- FIFO:
  - 2 entries, 64 bits each; head/tail pointers are 1 bit and wrap modulo 2; count is 0..2.
  - `out_valid` = (count!=0).
  - Pop on `out_valid && out_ready`.
  - Push and pop in the same cycle: count unchanged.
- Issue gating (count<2 in REQ, single outstanding request) guarantees count ≤1 at any push. Overflow is impossible; no full-drop logic needed.
- `imem_rsp_valid` in REQ is a protocol violation and is ignored (no push).

## Timing
- Reset (async) values:
  - state=REQ, count=0, pointers=0, `req_pc`=0.
  - `out_valid`=0, `pc_en`=0, `pc_ld`=0, `pc_next`=0.
  - `imem_req_valid` rises combinationally after reset release, since count=0.
- Reset mid-operation: the outstanding request is forgotten, and a late response after reset is ignored (state REQ).
- Outputs are combinational from state/FIFO, except that `pc_*` also depends combinationally on `redirect_valid`, `imem_req_ready` and `redirect_pc`.
- Latency:
  - Issue edge to response: the memory's latency L≥1.
  - Response to `out_valid`: 1 cycle (registered push).
  - Response edge to next issue: 1 cycle.
  - Steady-state throughput: 1 instruction per (L+1) cycles.
- Redirect in cycle t: the counter holds `redirect_pc` after edge t; the first request at the target issues in cycle t+1 (REQ) or the cycle after the stale response arrives (DISCARD).
- Back-pressure: with `out_ready`=0, the FIFO fills to 2, then `imem_req_valid` stays 0 and the PC does not advance.

## Test plan
- Reset release with ready memory (L=1) and `out_ready`=1 → `imem_addr` sequence 0,1,2…, one request per 2 cycles; `out_pc`=0,1,2 with matching `out_instr`; `pc_ld` never 1.
- `out_ready`=0 → exactly 2 requests (PC 0,1) issue; `imem_req_valid` stays 0 and `pc_q` holds at 2. Set `out_ready`=1 → pops 0 then 1, fetch resumes at 2.
- Redirect to 0x100 while WAIT (L=3) → `pc_ld`=1, `pc_next`=0x100 for one cycle; state DISCARD; the stale response is not pushed; next `imem_addr`=0x100; `out_pc`=0x100.
- Redirect on the same cycle as `imem_rsp_valid` in WAIT, with the FIFO holding one entry → FIFO empty next cycle, response dropped, request for the target issues the following cycle.
- `imem_req_ready` low for 5 cycles → `imem_req_valid` held high, `imem_addr` stable, `pc_en`=0 throughout; a single advance occurs on acceptance.
- `rst` asserted while WAIT with 1 FIFO entry, then a late `imem_rsp_valid` → all outputs at reset values, no push, `out_valid`=0.
